// File: rtl/dram_seq_pkg.sv
// Shared types and constants for the DRAM RAS/CAS sequencer and its refresh timer.
package dram_seq_pkg;

    localparam int PHASE_W = 4;
    localparam int REF_W   = 10;

    localparam int DEF_ROW_SETUP      = 1;
    localparam int DEF_RAS_TO_MUX     = 1;
    localparam int DEF_MUX_TO_CAS     = 1;
    localparam int DEF_CAS_CYCLES     = 2;
    localparam int DEF_PRECHARGE      = 2;
    localparam int DEF_REFRESH_PERIOD = 400;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ROW,
        ST_RAS,
        ST_COL,
        ST_CAS,
        ST_PRE,
        ST_REF_CAS,
        ST_REF_RAS,
        ST_REF_PRE
    } dram_state_e;

    // Phase counter reload value for a state lasting 'cycles' clocks.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with sticky pending and overrun flags.
module dram_refresh_timer
    import dram_seq_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
)(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic pend_o,
    output logic ovr_o
);

    logic [REF_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             due;

    // A new request due in the same cycle the old one is serviced stays pending.
    always_comb begin
        due    = (cnt_q == '0);
        cnt_d  = due ? REF_W'(REFRESH_PERIOD - 1) : cnt_q - REF_W'(1);
        pend_d = due | (pend_q & ~clr_i);
        ovr_d  = ovr_q | (due & pend_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= REF_W'(REFRESH_PERIOD - 1);
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pend_o = pend_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/dram_ras_cas_sequencer.sv
// DRAM RAS/CAS/mux-select sequencer; CAS-before-RAS refresh built in only
// when DRAM_SEQ_REFRESH_EN is defined.
module dram_ras_cas_sequencer
    import dram_seq_pkg::*;
#(
    parameter int ROW_SETUP      = DEF_ROW_SETUP,
    parameter int RAS_TO_MUX     = DEF_RAS_TO_MUX,
    parameter int MUX_TO_CAS     = DEF_MUX_TO_CAS,
    parameter int CAS_CYCLES     = DEF_CAS_CYCLES,
    parameter int PRECHARGE      = DEF_PRECHARGE,
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
)(
    input  logic CLK,
    input  logic _RST,
    input  logic REQ,
    input  logic RW,
    output logic ACK,
    output logic BUSY,
    output logic S,
    output logic _OE,
    output logic _RAS,
    output logic _CAS,
    output logic _WE,
    output logic REF_OVR
);

    dram_state_e        state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wr_q, wr_d;
    logic               done;
    logic ack_q, busy_q, s_q, oe_n_q, ras_n_q, cas_n_q, we_n_q;
    logic ack_d, busy_d, s_d, oe_n_d, ras_n_d, cas_n_d, we_n_d;

`ifdef DRAM_SEQ_REFRESH_EN
    logic ref_pend;
    logic ref_clr;

    assign ref_clr = (state_q == ST_IDLE) && ref_pend;

    dram_refresh_timer #(
        .REFRESH_PERIOD(REFRESH_PERIOD)
    ) u_refresh (
        .clk_i (CLK),
        .rst_ni(_RST),
        .clr_i (ref_clr),
        .pend_o(ref_pend),
        .ovr_o (REF_OVR)
    );
`else
    assign REF_OVR = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        done    = (phase_q == '0);
        phase_d = done ? phase_q : phase_q - PHASE_W'(1);
        case (state_q)
            ST_IDLE: begin
`ifdef DRAM_SEQ_REFRESH_EN
                if (ref_pend) begin
                    state_d = ST_REF_CAS;
                    phase_d = phase_load(1);
                end else
`endif
                if (REQ) begin
                    state_d = ST_ROW;
                    phase_d = phase_load(ROW_SETUP);
                    wr_d    = ~RW;
                end
            end
            ST_ROW: if (done) begin
                state_d = ST_RAS;
                phase_d = phase_load(RAS_TO_MUX);
            end
            ST_RAS: if (done) begin
                state_d = ST_COL;
                phase_d = phase_load(MUX_TO_CAS);
            end
            ST_COL: if (done) begin
                state_d = ST_CAS;
                phase_d = phase_load(CAS_CYCLES);
            end
            ST_CAS: if (done) begin
                state_d = ST_PRE;
                phase_d = phase_load(PRECHARGE);
            end
            ST_PRE: if (done) begin
                state_d = ST_IDLE;
            end
`ifdef DRAM_SEQ_REFRESH_EN
            ST_REF_CAS: if (done) begin
                state_d = ST_REF_RAS;
                phase_d = phase_load(CAS_CYCLES + 1);
            end
            ST_REF_RAS: if (done) begin
                state_d = ST_REF_PRE;
                phase_d = phase_load(1);
            end
            ST_REF_PRE: if (done) begin
                state_d = ST_PRE;
                phase_d = phase_load(PRECHARGE);
            end
`endif
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so each pin is a flop aligned with state_q.
    always_comb begin
        ack_d   = (state_d == ST_CAS) && (phase_d == '0);
        busy_d  = (state_d != ST_IDLE);
        s_d     = state_d inside {ST_COL, ST_CAS};
        oe_n_d  = !(state_d inside {ST_ROW, ST_RAS, ST_COL, ST_CAS});
        ras_n_d = !(state_d inside {ST_RAS, ST_COL, ST_CAS, ST_REF_RAS, ST_REF_PRE});
        cas_n_d = !(state_d inside {ST_CAS, ST_REF_CAS, ST_REF_RAS});
        we_n_d  = !(wr_d && (state_d inside {ST_ROW, ST_RAS, ST_COL, ST_CAS}));
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            s_q     <= 1'b0;
            oe_n_q  <= 1'b1;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            s_q     <= s_d;
            oe_n_q  <= oe_n_d;
            ras_n_q <= ras_n_d;
            cas_n_q <= cas_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign ACK  = ack_q;
    assign BUSY = busy_q;
    assign S    = s_q;
    assign _OE  = oe_n_q;
    assign _RAS = ras_n_q;
    assign _CAS = cas_n_q;
    assign _WE  = we_n_q;

endmodule

// File: tb/tb_dram_ras_cas_sequencer.sv
// Scoreboard bench: a waveform-template model predicts every output cycle of the sequencer.
module tb_dram_ras_cas_sequencer;

    localparam int RS = 1, RM = 1, MC = 1, CC = 2, PR = 2, RP = 20;
`ifdef DRAM_SEQ_REFRESH_EN
    localparam bit REF_ON = 1'b1;
`else
    localparam bit REF_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic _RST = 1'b0;
    logic REQ = 1'b0;
    logic RW = 1'b1;
    logic ACK, BUSY, S, _OE, _RAS, _CAS, _WE, REF_OVR;
    logic REQ2 = 1'b1;
    logic RW2 = 1'b1;
    logic ACK2, BUSY2, S2, OE2, RAS2, CAS2, WE2, REF_OVR2;

    always #5 CLK = ~CLK;

    dram_ras_cas_sequencer #(
        .ROW_SETUP(RS), .RAS_TO_MUX(RM), .MUX_TO_CAS(MC),
        .CAS_CYCLES(CC), .PRECHARGE(PR), .REFRESH_PERIOD(RP)
    ) dut (
        .CLK(CLK), ._RST(_RST), .REQ(REQ), .RW(RW),
        .ACK(ACK), .BUSY(BUSY), .S(S), ._OE(_OE),
        ._RAS(_RAS), ._CAS(_CAS), ._WE(_WE), .REF_OVR(REF_OVR)
    );

    // Refresh every 4 clocks with long accesses and REQ always high.
    dram_ras_cas_sequencer #(
        .CAS_CYCLES(8), .REFRESH_PERIOD(4)
    ) dut_ovr (
        .CLK(CLK), ._RST(_RST), .REQ(REQ2), .RW(RW2),
        .ACK(ACK2), .BUSY(BUSY2), .S(S2), ._OE(OE2),
        ._RAS(RAS2), ._CAS(CAS2), ._WE(WE2), .REF_OVR(REF_OVR2)
    );

    typedef logic [6:0] vec_t;  // {ACK,BUSY,S,_OE,_RAS,_CAS,_WE}

    vec_t expq[$];
    int   checks = 0;
    int   passed = 0;
    int   ec = 0;
    bit   pend = 1'b0;
    bit   ovr = 1'b0;

    function automatic vec_t mk(bit ack, bit busy, bit s, bit oe, bit ras, bit cas, bit we);
        return {ack, busy, s, oe, ras, cas, we};
    endfunction

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endfunction

    function automatic void push_access(bit wr);
        for (int i = 0; i < RS; i++) expq.push_back(mk(0, 1, 0, 0, 1, 1, !wr));
        for (int i = 0; i < RM; i++) expq.push_back(mk(0, 1, 0, 0, 0, 1, !wr));
        for (int i = 0; i < MC; i++) expq.push_back(mk(0, 1, 1, 0, 0, 1, !wr));
        for (int i = 0; i < CC; i++) expq.push_back(mk(i == CC - 1, 1, 1, 0, 0, 0, !wr));
        for (int i = 0; i < PR; i++) expq.push_back(mk(0, 1, 0, 1, 1, 1, 1));
        expq.push_back(mk(0, 0, 0, 1, 1, 1, 1));
    endfunction

    function automatic void push_refresh();
        expq.push_back(mk(0, 1, 0, 1, 1, 0, 1));
        for (int i = 0; i < CC + 1; i++) expq.push_back(mk(0, 1, 0, 1, 0, 0, 1));
        expq.push_back(mk(0, 1, 0, 1, 0, 1, 1));
        for (int i = 0; i < PR; i++) expq.push_back(mk(0, 1, 0, 1, 1, 1, 1));
        expq.push_back(mk(0, 0, 0, 1, 1, 1, 1));
    endfunction

    // Model: whenever the previous sequence has been fully predicted, decide the next one.
    always @(posedge CLK) begin
        bit old_pend;
        if (!_RST) begin
            expq.delete();
            ec   = 0;
            pend = 1'b0;
            ovr  = 1'b0;
        end else begin
            ec++;
            old_pend = pend;
            if (expq.size() == 0) begin
                if (pend) begin
                    push_refresh();
                    pend = 1'b0;
                end else if (REQ) begin
                    push_access(!RW);
                end else begin
                    expq.push_back(mk(0, 0, 0, 1, 1, 1, 1));
                end
            end
            if (REF_ON && (ec % RP == 0)) begin
                if (old_pend) ovr = 1'b1;
                pend = 1'b1;
            end
        end
    end

    // Monitor: compare the DUT outputs against the scoreboard once per cycle.
    always @(negedge CLK) begin
        vec_t act;
        vec_t e;
        act = {ACK, BUSY, S, _OE, _RAS, _CAS, _WE};
        if (!_RST) begin
            chk("reset_outputs", int'(act), int'(mk(0, 0, 0, 1, 1, 1, 1)));
        end else if (expq.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: got no expectation, required one at t=%0t", $time);
        end else begin
            e = expq.pop_front();
            chk("cycle_outputs", int'(act), int'(e));
        end
        chk("ref_ovr", int'(REF_OVR), int'(ovr));
        chk("ref_ovr_long", int'(REF_OVR2), int'(REF_ON && _RST && ec >= 8));
    end

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (REQ) begin
                if (ACK) REQ = 1'b0;
                else if ($urandom_range(0, 19) == 0) REQ = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                REQ = 1'b1;
                RW  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge CLK);
        #2 _RST = 1'b1;

        // Directed read then write with default timing.
        @(negedge CLK);
        REQ = 1'b1; RW = 1'b1;
        repeat (6) @(negedge CLK);
        REQ = 1'b0;
        repeat (4) @(negedge CLK);
        REQ = 1'b1; RW = 1'b0;
        repeat (6) @(negedge CLK);
        REQ = 1'b0;
        repeat (4) @(negedge CLK);

        random_phase(1500);

        // Async reset in the middle of an access CAS phase.
        REQ = 1'b1; RW = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (!_CAS && S) found = 1'b1;
        end
        if (!found) begin
            checks++;
            $display("FAIL cas_wait: got no CAS phase, required one within 60 cycles");
        end
        #2 _RST = 1'b0;
        REQ = 1'b0;
        #1;
        chk("async_reset_outputs", int'({ACK, BUSY, S, _OE, _RAS, _CAS, _WE}),
            int'(mk(0, 0, 0, 1, 1, 1, 1)));
        chk("async_reset_ovr", int'({REF_OVR, REF_OVR2}), 0);
        repeat (3) @(negedge CLK);
        #2 _RST = 1'b1;

        random_phase(400);
        @(negedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dram_ras_cas_sequencer.md
Name: dram_ras_cas_sequencer

Overview:
- Upstream DRAM timing stage for the 74F257 row/column address multiplexers.
- Drives their shared select S (0 = row, 1 = column) and shared tristate enable _OE.
- Also drives the DRAM strobes _RAS, _CAS and _WE.
- Accepts single-word access requests from the bus arbiter via a REQ/ACK handshake and interleaves CAS-before-RAS refresh.

Parameters:
- ROW_SETUP, 1, cycles the row address is muxed out before _RAS falls (1..15).
- RAS_TO_MUX, 1, cycles _RAS is low before S switches to column (1..15).
- MUX_TO_CAS, 1, cycles the column address is stable before _CAS falls (1..15).
- CAS_CYCLES, 2, cycles _CAS is held low (1..15).
- PRECHARGE, 2, cycles of _RAS-high precharge after any cycle (1..15).
- REFRESH_PERIOD, 400, clock cycles between refresh requests (2..1023).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- _RST  in  1  asynchronous, active-low reset.
- REQ  in  1  access request, held high until ACK.
- RW  in  1  1 = read, 0 = write; sampled with REQ.
- ACK  out  1  one-cycle pulse marking the final _CAS-low cycle of an access.
- BUSY  out  1  high in every state except IDLE.
- S  out  1  mux select to the 74F257 devices.
- _OE  out  1  mux output enable; active low.
- _RAS  out  1  DRAM row strobe; active low.
- _CAS  out  1  DRAM column strobe; active low.
- _WE  out  1  DRAM write enable; active low.
- REF_OVR  out  1  sticky flag: a refresh came due while one was already pending.

Behaviour:
- Reset (async assert): all outputs go inactive immediately.
  - _RAS = _CAS = _WE = _OE = 1; S = ACK = BUSY = REF_OVR = 0.
  - State returns to IDLE; timers and the pending flag clear.
  - Reset mid-cycle truncates the cycle with no ACK.
  - Deassertion is used as-is; synchronization happens upstream.
- All outputs are registered. One 4-bit phase counter loads (parameter - 1) on state entry and counts down; the state exits at 0.
- Per-state outputs:
  - IDLE: _OE = 1, S = 0, strobes high.
  - ROW (ROW_SETUP cycles): _OE = 0, S = 0.
  - RAS (RAS_TO_MUX cycles): _RAS = 0, S = 0, _OE = 0.
  - COL (MUX_TO_CAS cycles): _RAS = 0, S = 1, _OE = 0.
  - CAS (CAS_CYCLES cycles): _RAS = 0, _CAS = 0, S = 1, _OE = 0. ACK = 1 on the last CAS cycle only.
  - PRE (PRECHARGE cycles): strobes high, _OE = 1, S = 0.
  - REF_CAS (1 cycle): _CAS = 0, _OE = 1.
  - REF_RAS (CAS_CYCLES + 1 cycles): _CAS = 0, _RAS = 0, _OE = 1.
  - REF_PRE then goes to PRE.
- _WE is latched as !RW when a request is accepted. It is 0 only in ROW through CAS of a write; otherwise 1.
- IDLE arbitration: a pending refresh wins over REQ, and the pending flag clears on entry to REF_CAS. Otherwise REQ = 1 goes to ROW. IDLE always lasts at least 1 cycle.
- With defaults, ACK is asserted in the 5th cycle after the edge that samples REQ in IDLE.
- Handshake: the master drops REQ on the cycle after ACK. If REQ drops early, the cycle still completes and ACK still pulses. REQ high in IDLE means a new request.
- _OE is always 1 whenever _RAS and _CAS are both being changed by refresh. The muxes never drive during refresh.

Optional Feature:
- DRAM_SEQ_REFRESH_EN defined:
  - The internal 10-bit refresh timer runs and counts down from REFRESH_PERIOD - 1.
  - On reaching 0 it reloads and sets pending.
  - If pending is already set at that moment, REF_OVR sets and stays set until reset.
- DRAM_SEQ_REFRESH_EN undefined:
  - No timer and no REF_* states.
  - REF_OVR is tied to 0; refresh is owned externally.

Decomposition:
- dram_seq_pkg holds:
  - The state enum: IDLE, ROW, RAS, COL, CAS, PRE, REF_CAS, REF_RAS, REF_PRE.
  - The phase-counter width of 4 and refresh-timer width of 10.
  - The default timing constants.
- Sub-module dram_refresh_timer (count, reload, pending/overrun logic) is instantiated only under DRAM_SEQ_REFRESH_EN.

Test Plan:
- Read access, defaults: REQ = 1, RW = 1 in IDLE at cycle 0 ->
  - S = 0 / _OE = 0 at cycle 1, _RAS = 0 at cycle 2, S = 1 at cycle 3.
  - _CAS = 0 at cycles 4-5, ACK only at cycle 5.
  - _RAS = _CAS = _OE = 1 at cycles 6-7, IDLE at cycle 8; _WE = 1 throughout.
- Write access: RW = 0 -> same timing as the read, with _WE = 0 from cycles 1-5 and 1 from cycle 6.
- Back-to-back: REQ re-raised at cycle 7 -> the second ROW starts at cycle 9, and BUSY = 0 for exactly 1 cycle between the accesses.
- Refresh vs request, REFRESH_PERIOD = 20, REFRESH_EN on:
  - Pending and REQ are both high in IDLE -> REF_CAS first.
  - _CAS falls 1 cycle before _RAS, _OE = 1 throughout.
  - The access follows after PRE.
- Overrun: REFRESH_PERIOD = 4, REQ held continuously, CAS_CYCLES = 8 -> REF_OVR = 1 and stays 1 until _RST = 0.
- Async reset: _RST = 0 during CAS -> all outputs inactive with no clock edge; no ACK; IDLE after release.
